// File: rtl/rgb_fade_sequencer.sv
// Autonomous four-scene RGB fader: ramps three 8-bit levels toward the active scene, holds, advances.
// Optional macro RGB_FADE_GAMMA_EN squares the levels on the duty outputs.
module rgb_fade_sequencer #(
  parameter int unsigned PRESCALE   = 1024,
  parameter int unsigned HOLD_TICKS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [1:0]  load_idx,
  input  logic [23:0] load_rgb,
  output logic [7:0]  duty0,
  output logic [7:0]  duty1,
  output logic [7:0]  duty2,
  output logic        duty_update,
  output logic [1:0]  scene_idx,
  output logic        busy
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [1:0]         scene_q, scene_d;
  logic [2:0][7:0]    level_q, level_d;
  logic [3:0][23:0]   scenes_q, scenes_d;
  logic               duty_update_q;

  logic               tick_s;
  logic               load_ready_s;
  logic               at_target_s;
  logic [23:0]        target_s;
  logic [2:0][7:0]    tgt_s;
  logic [2:0][7:0]    stepped_s;

  function automatic logic [7:0] step_toward(input logic [7:0] lvl, input logic [7:0] tgt);
    if (lvl < tgt) begin
      return lvl + 8'd1;
    end else if (lvl > tgt) begin
      return lvl - 8'd1;
    end else begin
      return lvl;
    end
  endfunction

`ifdef RGB_FADE_GAMMA_EN
  function automatic logic [7:0] gamma(input logic [7:0] lvl);
    return 8'(((16'(lvl) * 16'(lvl)) + 16'd255) >> 8);
  endfunction
`endif

  // Target lookup, single-step toward it, and the shared fade/hold tick.
  always_comb begin
    target_s     = scenes_q[scene_q];
    tgt_s[0]     = target_s[23:16];
    tgt_s[1]     = target_s[15:8];
    tgt_s[2]     = target_s[7:0];
    for (int i = 0; i < 3; i++) begin
      stepped_s[i] = step_toward(level_q[i], tgt_s[i]);
    end
    at_target_s  = (stepped_s == tgt_s);
    tick_s       = (state_q != ST_IDLE) && (presc_q == PRESC_MAX);
    load_ready_s = (state_q != ST_FADE);
  end

  // Sequencer next-state: scene advance, level ramping, prescaler and hold counting.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    scene_d  = scene_q;
    level_d  = level_q;
    scenes_d = scenes_q;
    if (load_valid && load_ready_s) begin
      scenes_d[load_idx] = load_rgb;
    end else begin
      scenes_d = scenes_q;
    end
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        scene_d = step ? (scene_q + 2'd1) : scene_q;
        state_d = (run || step) ? ST_FADE : ST_IDLE;
      end
      ST_FADE: begin
        presc_d = tick_s ? '0 : (presc_q + PW'(1));
        if (tick_s) begin
          level_d = stepped_s;
          if (at_target_s) begin
            state_d = run ? ST_HOLD : ST_IDLE;
            hold_d  = '0;
          end else begin
            state_d = ST_FADE;
          end
        end else begin
          level_d = level_q;
        end
      end
      ST_HOLD: begin
        presc_d = tick_s ? '0 : (presc_q + PW'(1));
        if (tick_s && (hold_q == HOLD_MAX)) begin
          scene_d = scene_q + 2'd1;
          state_d = run ? ST_FADE : ST_IDLE;
        end else if (tick_s) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // State and datapath registers; scene memory reverts to its defaults on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      hold_q        <= '0;
      scene_q       <= 2'd0;
      level_q       <= '0;
      scenes_q[0]   <= 24'hFF0000;
      scenes_q[1]   <= 24'h00FF00;
      scenes_q[2]   <= 24'h0000FF;
      scenes_q[3]   <= 24'h000000;
      duty_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      hold_q        <= hold_d;
      scene_q       <= scene_d;
      level_q       <= level_d;
      scenes_q      <= scenes_d;
      duty_update_q <= (level_d != level_q);
    end
  end

  assign load_ready  = load_ready_s;
  assign busy        = (state_q != ST_IDLE);
  assign scene_idx   = scene_q;
  assign duty_update = duty_update_q;

`ifdef RGB_FADE_GAMMA_EN
  assign duty0 = gamma(level_q[0]);
  assign duty1 = gamma(level_q[1]);
  assign duty2 = gamma(level_q[2]);
`else
  assign duty0 = level_q[0];
  assign duty1 = level_q[1];
  assign duty2 = level_q[2];
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with PRESCALE=4, HOLD_TICKS=2.
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [1:0]  load_idx = 2'd0;
  logic [23:0] load_rgb = 24'd0;
  logic [7:0]  duty0, duty1, duty2;
  logic        duty_update;
  logic [1:0]  scene_idx;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;

  rgb_fade_sequencer #(.PRESCALE(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx), .load_rgb(load_rgb),
    .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty_update(duty_update),
    .scene_idx(scene_idx), .busy(busy)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(negedge clk) begin
    if (duty_update === 1'b1) upd_seen++;
  end

  typedef struct {
    logic        run;
    int unsigned ncyc;
    logic [7:0]  d0, d1, d2;
    logic [1:0]  sc;
    logic        bsy;
    logic        rdy;
    int          upd;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [7:0] gx(input logic [7:0] l);
`ifdef RGB_FADE_GAMMA_EN
    int sq;
    sq = int'(l) * int'(l) + 255;
    return 8'(sq >> 8);
`else
    return l;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [1:0] sc, input logic bsy, input logic rdy);
    chk({tag, ".duty0"}, 32'(duty0), 32'(gx(d0)));
    chk({tag, ".duty1"}, 32'(duty1), 32'(gx(d1)));
    chk({tag, ".duty2"}, 32'(duty2), 32'(gx(d2)));
    chk({tag, ".scene"}, 32'(scene_idx), 32'(sc));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".ready"}, 32'(load_ready), 32'(rdy));
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Cumulative checkpoints of a continuous run from reset; upd counts duty_update pulses so far.
    vecs[0]  = '{1'b1, 1,    8'd0,   8'd0,   8'd0, 2'd0, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b1, 4,    8'd1,   8'd0,   8'd0, 2'd0, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b1, 3,    8'd1,   8'd0,   8'd0, 2'd0, 1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 1,    8'd2,   8'd0,   8'd0, 2'd0, 1'b1, 1'b0, 2};
    vecs[4]  = '{1'b1, 1012, 8'd255, 8'd0,   8'd0, 2'd0, 1'b1, 1'b1, 255};
    vecs[5]  = '{1'b1, 7,    8'd255, 8'd0,   8'd0, 2'd0, 1'b1, 1'b1, 255};
    vecs[6]  = '{1'b1, 1,    8'd255, 8'd0,   8'd0, 2'd1, 1'b1, 1'b0, 255};
    vecs[7]  = '{1'b1, 4,    8'd254, 8'd1,   8'd0, 2'd1, 1'b1, 1'b0, 256};
    vecs[8]  = '{1'b1, 1016, 8'd0,   8'd255, 8'd0, 2'd1, 1'b1, 1'b1, 510};
    vecs[9]  = '{1'b0, 8,    8'd0,   8'd255, 8'd0, 2'd2, 1'b0, 1'b1, 510};
    vecs[10] = '{1'b0, 5,    8'd0,   8'd255, 8'd0, 2'd2, 1'b0, 1'b1, 510};

    // Asynchronous reset with the clock stopped.
    #3 rst_n = 1'b0;
    #1;
    chk_state("rst", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
    chk("rst.upd", 32'(duty_update), 32'd0);
    clk_en = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run = vecs[i].run;
      cyc(vecs[i].ncyc);
      chk_state($sformatf("v%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d2,
                vecs[i].sc, vecs[i].bsy, vecs[i].rdy);
      chk($sformatf("v%0d.upd_count", i), 32'(upd_seen + int'(duty_update)), 32'(vecs[i].upd));
    end

    // Load scene 3 while idle, then single-step into it; levels are 0,255,0 here.
    load_valid = 1'b1; load_idx = 2'd3; load_rgb = 24'h102030;
    chk("load.ready_idle", 32'(load_ready), 32'd1);
    cyc(1);
    load_valid = 1'b0;
    chk("load.ready_after", 32'(load_ready), 32'd1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk_state("step.entry", 8'd0, 8'd255, 8'd0, 2'd3, 1'b1, 1'b0);
    cyc(9);
    chk_state("step.t2", 8'd2, 8'd253, 8'd2, 2'd3, 1'b1, 1'b0);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("step.ignored", 32'(scene_idx), 32'd3);
    cyc(881);
    chk_state("step.near", 8'd16, 8'd33, 8'd48, 2'd3, 1'b1, 1'b0);
    cyc(1);
    chk_state("step.done", 8'd16, 8'd32, 8'd48, 2'd3, 1'b0, 1'b1);
    chk("step.done_upd", 32'(duty_update), 32'd1);
    cyc(1);
    chk("step.idle_upd", 32'(duty_update), 32'd0);
    chk("step.no_hold", 32'(busy), 32'd0);

    // Run from scene 3 (already at target); hold load_valid through the fade into HOLD.
    run = 1'b1;
    cyc(1);
    load_valid = 1'b1; load_idx = 2'd0; load_rgb = 24'h800000;
    chk_state("rt.fade", 8'd16, 8'd32, 8'd48, 2'd3, 1'b1, 1'b0);
    cyc(3);
    chk("rt.ready_fade", 32'(load_ready), 32'd0);
    cyc(1);
    chk_state("rt.hold", 8'd16, 8'd32, 8'd48, 2'd3, 1'b1, 1'b1);
    chk("rt.hold_upd", 32'(duty_update), 32'd0);
    cyc(1);
    load_valid = 1'b0;
    cyc(7);
    chk_state("rt.wrap", 8'd16, 8'd32, 8'd48, 2'd0, 1'b1, 1'b0);
    cyc(447);
    chk_state("rt.near", 8'd127, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    cyc(1);
    chk_state("rt.done", 8'd128, 8'd0, 8'd0, 2'd0, 1'b1, 1'b1);

    // Reset in the middle of operation; scene 0 must revert to FF0000.
    #3 rst_n = 1'b0;
    #1;
    chk_state("mrst", 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
    chk("mrst.upd", 32'(duty_update), 32'd0);
    run = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b1;
    cyc(517);
    chk_state("mrst.scene0", 8'd129, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
